blackparrot_fpga_host_axil_csr_bridge: RTL and testbench

Parametrised AXI4-Lite subordinate that maps host 32b CSR reads and writes onto N read-FIFO channels and M write-FIFO channels. It generalises the fixed read and write CSR converters. CSR addresses are computed as base plus 4*index, so no address list is needed. Unmapped accesses, partial-strobe writes and stalled channels return error responses. The block sits between the host AXI-Lite port and the NBF/MMIO FIFO interfaces of the FPGA host.

---
 rtl/blackparrot_fpga_host_axil_csr_bridge_if.sv | 38 +++
 rtl/blackparrot_fpga_host_axil_csr_bridge.sv | 255 +++++++++++++++++++++++++
 tb/tb_blackparrot_fpga_host_axil_csr_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blackparrot_fpga_host_axil_csr_bridge_if.sv
// AXI4-Lite bus bundle between the host port and the CSR bridge.
// The master modport is the host side; the slave modport is the bridge side.
interface blackparrot_fpga_host_axil_csr_bridge_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [2:0]          awprot;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [2:0]          arprot;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;
  logic [1:0]          rresp;

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
  );
endinterface

// File: rtl/blackparrot_fpga_host_axil_csr_bridge.sv
// AXI4-Lite subordinate mapping 32b host CSR accesses onto N read FIFOs and M write FIFOs.
// Independent read and write FSMs, per-transaction timeout, saturating error counter.
module blackparrot_fpga_host_axil_csr_bridge #(
  parameter int                             S_AXIL_ADDR_WIDTH = 64,
  parameter int                             S_AXIL_DATA_WIDTH = 32,
  parameter int                             RD_CSR_ELS        = 4,
  parameter int                             WR_CSR_ELS        = 2,
  parameter logic [S_AXIL_ADDR_WIDTH-1:0]   RD_BASE_ADDR      = 'h8,
  parameter logic [S_AXIL_ADDR_WIDTH-1:0]   WR_BASE_ADDR      = 'h0,
  parameter int                             TIMEOUT_CYCLES    = 1024,
  parameter int                             ERR_CNT_WIDTH     = 16
) (
  input  logic                                      s_axil_aclk,
  input  logic                                      s_axil_aresetn,
  blackparrot_fpga_host_axil_csr_bridge_if.slave    s_axil,
  input  logic [RD_CSR_ELS-1:0]                     rd_fifo_v_i,
  output logic [RD_CSR_ELS-1:0]                     rd_fifo_yumi_o,
  input  logic [RD_CSR_ELS*S_AXIL_DATA_WIDTH-1:0]   rd_fifo_data_i,
  output logic [WR_CSR_ELS-1:0]                     wr_fifo_v_o,
  input  logic [WR_CSR_ELS-1:0]                     wr_fifo_ready_and_i,
  output logic [S_AXIL_DATA_WIDTH-1:0]              wr_fifo_data_o,
  output logic [ERR_CNT_WIDTH-1:0]                  error_count_o
);
  localparam int AW  = S_AXIL_ADDR_WIDTH;
  localparam int DW  = S_AXIL_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int RIW = (RD_CSR_ELS > 1) ? $clog2(RD_CSR_ELS) : 1;
  localparam int WIW = (WR_CSR_ELS > 1) ? $clog2(WR_CSR_ELS) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit            TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} w_state_e;

  // Result is {hit, channel index}; full-width compare against base + 4*i.
  function automatic logic [RIW:0] rd_decode(input logic [AW-1:0] a);
    logic [RIW:0] res;
    res = '0;
    for (int i = 0; i < RD_CSR_ELS; i++)
      if (a == RD_BASE_ADDR + AW'(4 * i)) res = {1'b1, RIW'(i)};
    return res;
  endfunction

  function automatic logic [WIW:0] wr_decode(input logic [AW-1:0] a);
    logic [WIW:0] res;
    res = '0;
    for (int j = 0; j < WR_CSR_ELS; j++)
      if (a == WR_BASE_ADDR + AW'(4 * j)) res = {1'b1, WIW'(j)};
    return res;
  endfunction

  r_state_e          r_rstate;
  logic              r_arready, r_rvalid;
  logic [DW-1:0]     r_rdata;
  logic [1:0]        r_rresp;
  logic [RIW-1:0]    r_ridx;
  logic [TW-1:0]     r_rtimer;

  w_state_e          r_wstate;
  logic              r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  logic [AW-1:0]     r_awaddr;
  logic [DW-1:0]     r_wdata, r_wfifo_data;
  logic [SW-1:0]     r_wstrb;
  logic [WR_CSR_ELS-1:0] r_wv;
  logic [1:0]        r_bresp;
  logic [TW-1:0]     r_wtimer;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic [RIW:0]      w_ar_dec;
  logic [WIW:0]      w_aw_dec;
  logic [DW-1:0]     w_rd_data;
  logic              w_rd_v;
  logic [1:0]        w_err_inc;
  logic [ERR_CNT_WIDTH:0] w_err_sum;
  logic              w_unused_prot;

  assign w_ar_dec      = rd_decode(s_axil.araddr);
  assign w_aw_dec      = wr_decode(r_awaddr);
  assign w_unused_prot = ^{s_axil.awprot, s_axil.arprot};

  always_comb begin
    w_rd_data      = '0;
    w_rd_v         = 1'b0;
    rd_fifo_yumi_o = '0;
    for (int i = 0; i < RD_CSR_ELS; i++) begin
      if (r_ridx == RIW'(i)) begin
        w_rd_data = rd_fifo_data_i[i*DW +: DW];
        w_rd_v    = rd_fifo_v_i[i];
        if (r_rstate == R_WAIT) rd_fifo_yumi_o[i] = rd_fifo_v_i[i];
      end
    end
  end

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_ridx    <= '0;
      r_rtimer  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (r_arready && s_axil.arvalid) begin
            r_arready <= 1'b0;
            r_rtimer  <= '0;
            if (w_ar_dec[RIW]) begin
              r_ridx   <= w_ar_dec[RIW-1:0];
              r_rstate <= R_WAIT;
            end else begin
              r_rdata  <= '0;
              r_rresp  <= RESP_DECERR;
              r_rvalid <= 1'b1;
              r_rstate <= R_RESP;
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (w_rd_v) begin
            r_rdata  <= w_rd_data;
            r_rresp  <= RESP_OKAY;
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end else if (TO_EN && r_rtimer == TLAST) begin
            r_rdata  <= '0;
            r_rresp  <= RESP_SLVERR;
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end else begin
            r_rtimer <= r_rtimer + 1'b1;
          end
        end
        R_RESP: begin
          if (s_axil.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // AW and W are captured independently; decode waits until both are held.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      r_wstate     <= W_IDLE;
      r_awready    <= 1'b0;
      r_wready     <= 1'b0;
      r_aw_held    <= 1'b0;
      r_w_held     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wv         <= '0;
      r_wfifo_data <= '0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
      r_wtimer     <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_aw_held && r_w_held) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wtimer  <= '0;
            if (!w_aw_dec[WIW]) begin
              r_bresp  <= RESP_DECERR;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end else if (r_wstrb != '1) begin
              r_bresp  <= RESP_SLVERR;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end else begin
              r_wv         <= WR_CSR_ELS'(1) << w_aw_dec[WIW-1:0];
              r_wfifo_data <= r_wdata;
              r_wstate     <= W_PUSH;
            end
          end else begin
            if (r_awready && s_axil.awvalid) begin
              r_awaddr  <= s_axil.awaddr;
              r_aw_held <= 1'b1;
              r_awready <= 1'b0;
            end else if (!r_aw_held) begin
              r_awready <= 1'b1;
            end
            if (r_wready && s_axil.wvalid) begin
              r_wdata  <= s_axil.wdata;
              r_wstrb  <= s_axil.wstrb;
              r_w_held <= 1'b1;
              r_wready <= 1'b0;
            end else if (!r_w_held) begin
              r_wready <= 1'b1;
            end
          end
        end
        W_PUSH: begin
          if (|(r_wv & wr_fifo_ready_and_i)) begin
            r_wv     <= '0;
            r_bresp  <= RESP_OKAY;
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end else if (TO_EN && r_wtimer == TLAST) begin
            r_wv     <= '0;
            r_bresp  <= RESP_SLVERR;
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end else begin
            r_wtimer <= r_wtimer + 1'b1;
          end
        end
        W_RESP: begin
          if (s_axil.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read and write error handshakes in the same cycle add two; the count saturates.
  assign w_err_inc = {1'b0, r_rvalid && s_axil.rready && (r_rresp != RESP_OKAY)}
                   + {1'b0, r_bvalid && s_axil.bready && (r_bresp != RESP_OKAY)};
  assign w_err_sum = {1'b0, r_err_cnt} + (ERR_CNT_WIDTH+1)'(w_err_inc);

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) r_err_cnt <= '0;
    else if (w_err_sum[ERR_CNT_WIDTH]) r_err_cnt <= '1;
    else r_err_cnt <= w_err_sum[ERR_CNT_WIDTH-1:0];
  end

  assign s_axil.arready = r_arready;
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rdata   = r_rdata;
  assign s_axil.rresp   = r_rresp;
  assign s_axil.awready = r_awready;
  assign s_axil.wready  = r_wready;
  assign s_axil.bvalid  = r_bvalid;
  assign s_axil.bresp   = r_bresp;
  assign wr_fifo_v_o    = r_wv;
  assign wr_fifo_data_o = r_wfifo_data;
  assign error_count_o  = r_err_cnt;
endmodule

// File: tb/tb_blackparrot_fpga_host_axil_csr_bridge.sv
// Directed and randomized bench for the AXI-Lite CSR bridge, with an address-arithmetic
// reference model for responses, FIFO side effects and the saturating error count.
module tb_blackparrot_fpga_host_axil_csr_bridge;
  localparam int AW = 64, DW = 32, RD = 4, WR = 2, TO = 8, EW = 3;
  localparam logic [63:0] RB = 64'h8, WB = 64'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RD-1:0]    rd_v;
  logic [RD-1:0]    yumi;
  logic [RD*DW-1:0] rd_data;
  logic [WR-1:0]    wv;
  logic [WR-1:0]    wrdy;
  logic [DW-1:0]    wdat;
  logic [EW-1:0]    errc;

  int n_vec = 0;
  int n_err = 0;

  blackparrot_fpga_host_axil_csr_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) axil ();

  blackparrot_fpga_host_axil_csr_bridge #(
    .S_AXIL_ADDR_WIDTH(AW), .S_AXIL_DATA_WIDTH(DW), .RD_CSR_ELS(RD), .WR_CSR_ELS(WR),
    .RD_BASE_ADDR(RB), .WR_BASE_ADDR(WB), .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(EW)
  ) dut (
    .s_axil_aclk(clk), .s_axil_aresetn(rst_n), .s_axil(axil),
    .rd_fifo_v_i(rd_v), .rd_fifo_yumi_o(yumi), .rd_fifo_data_i(rd_data),
    .wr_fifo_v_o(wv), .wr_fifo_ready_and_i(wrdy), .wr_fifo_data_o(wdat),
    .error_count_o(errc)
  );

  always #5 clk = ~clk;

  // FIFO-side event monitor, sampled mid-cycle.
  int yumi_cnt = 0;
  int push_cnt = 0;
  logic [RD-1:0] last_yumi = '0;
  logic [WR-1:0] last_push_v = '0;
  logic [DW-1:0] last_push_d = '0;
  logic multi_hot = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (yumi != '0) begin
        yumi_cnt  <= yumi_cnt + $countones(yumi);
        last_yumi <= yumi;
      end
      if ((wv & wrdy) != '0) begin
        push_cnt    <= push_cnt + 1;
        last_push_v <= wv;
        last_push_d <= wdat;
      end
      if ($countones(yumi) > 1 || $countones(wv) > 1) multi_hot <= 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_xact(input logic [63:0] addr, input int rdelay,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    logic [31:0] d0;
    logic [1:0] r0;
    axil.araddr = addr;
    axil.arvalid = 1'b1;
    n = 0;
    while (axil.arready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) chk("arready_bound", axil.arready, 1'b1);
    tick();
    axil.arvalid = 1'b0;
    lat = 1;
    while (axil.rvalid !== 1'b1 && lat < 100) begin tick(); lat++; end
    d0 = axil.rdata;
    r0 = axil.rresp;
    for (int k = 0; k < rdelay; k++) begin
      tick();
      chk("r_hold_valid", axil.rvalid, 1'b1);
      chk("r_hold_data", axil.rdata, d0);
      chk("r_hold_resp", axil.rresp, r0);
    end
    axil.rready = 1'b1;
    data = axil.rdata;
    resp = axil.rresp;
    tick();
    axil.rready = 1'b0;
  endtask

  task automatic wr_xact(input logic [63:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int aw_start, input int w_start, input int stall,
                         input logic [1:0] vexp, input int bdelay,
                         output logic [1:0] resp, output int lat);
    int i, k;
    logic aw_done, w_done, hs_aw, hs_w;
    logic [1:0] b0;
    aw_done = 1'b0; w_done = 1'b0; i = 0;
    while (!(aw_done && w_done) && i < 40) begin
      if (!aw_done && i >= aw_start) begin axil.awvalid = 1'b1; axil.awaddr = addr; end
      if (!w_done && i >= w_start) begin axil.wvalid = 1'b1; axil.wdata = data; axil.wstrb = strb; end
      hs_aw = axil.awvalid && axil.awready;
      hs_w  = axil.wvalid && axil.wready;
      tick();
      i++;
      if (hs_aw) begin axil.awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin axil.wvalid = 1'b0;  w_done = 1'b1;  end
    end
    if (!(aw_done && w_done)) chk("aw_w_accept", {aw_done, w_done}, 2'b11);
    lat = 0; k = 0;
    while (axil.bvalid !== 1'b1 && lat < 100) begin
      if (wv != '0) begin
        if (k < stall) begin
          wrdy = '0;
          chk("push_v_hold", wv, vexp);
          chk("push_d_hold", wdat, data);
          k++;
        end else wrdy = '1;
      end else wrdy = '0;
      tick();
      lat++;
    end
    wrdy = '0;
    b0 = axil.bresp;
    for (int m = 0; m < bdelay; m++) begin
      tick();
      chk("b_hold_valid", axil.bvalid, 1'b1);
      chk("b_hold_resp", axil.bresp, b0);
    end
    axil.bready = 1'b1;
    resp = axil.bresp;
    tick();
    axil.bready = 1'b0;
  endtask

  initial begin
    logic [31:0] d, exp_d;
    logic [1:0] r, exp_r, exp_v;
    int lat, exp_lat, y0, p0, err_exp, ch, stall, sel;
    logic [63:0] addr;
    logic [31:0] wd;
    logic [3:0] strb;
    logic push_exp;
    logic [31:0] r_d0;
    logic [1:0] r_r0, b_r0;

    axil.awaddr = '0; axil.awvalid = 1'b0; axil.awprot = 3'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0; axil.bready = 1'b0;
    axil.araddr = '0; axil.arvalid = 1'b0; axil.arprot = 3'b0; axil.rready = 1'b0;
    rd_v = '0; rd_data = '0; wrdy = '0;
    err_exp = 0;

    // Reset state
    #1;
    chk("rst_arready", axil.arready, 1'b0);
    chk("rst_awready", axil.awready, 1'b0);
    chk("rst_wready", axil.wready, 1'b0);
    chk("rst_rvalid", axil.rvalid, 1'b0);
    chk("rst_bvalid", axil.bvalid, 1'b0);
    chk("rst_wv", wv, '0);
    chk("rst_yumi", yumi, '0);
    chk("rst_errc", errc, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_arready", axil.arready, 1'b1);
    chk("post_rst_awready", axil.awready, 1'b1);
    chk("post_rst_wready", axil.wready, 1'b1);

    // Read channel 2 with data already available
    rd_v = 4'b0100;
    rd_data[2*DW +: DW] = 32'hCAFE0001;
    y0 = yumi_cnt;
    rd_xact(64'h10, 2, d, r, lat);
    chk("rd2_lat", lat, 2);
    chk("rd2_data", d, 32'hCAFE0001);
    chk("rd2_resp", r, 2'b00);
    chk("rd2_yumi_cnt", yumi_cnt - y0, 1);
    chk("rd2_yumi_vec", last_yumi, 4'b0100);
    rd_v = '0;

    // Write to 'h4, W three cycles ahead of AW, ready held off five cycles
    p0 = push_cnt;
    wr_xact(64'h4, 32'h12345678, 4'hF, 3, 0, 5, 2'b10, 1, r, lat);
    chk("wr1_resp", r, 2'b00);
    chk("wr1_lat", lat, 7);
    chk("wr1_push_cnt", push_cnt - p0, 1);
    chk("wr1_push_v", last_push_v, 2'b10);
    chk("wr1_push_d", last_push_d, 32'h12345678);
    chk("wr1_errc", errc, 0);

    // Unmapped read
    rd_v = '1;
    y0 = yumi_cnt;
    rd_xact(64'h40, 0, d, r, lat);
    err_exp = 1;
    chk("rdun_resp", r, 2'b11);
    chk("rdun_data", d, 32'h0);
    chk("rdun_lat", lat, 1);
    chk("rdun_yumi", yumi_cnt - y0, 0);
    chk("rdun_errc", errc, err_exp);
    rd_v = '0;

    // Partial-strobe write
    p0 = push_cnt;
    wr_xact(64'h4, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 2'b10, 0, r, lat);
    err_exp = 2;
    chk("wrpart_resp", r, 2'b10);
    chk("wrpart_lat", lat, 1);
    chk("wrpart_push", push_cnt - p0, 0);
    chk("wrpart_errc", errc, err_exp);

    // Read timeout on channel 0
    y0 = yumi_cnt;
    rd_xact(64'h8, 0, d, r, lat);
    err_exp = 3;
    chk("rdto_lat", lat, TO + 1);
    chk("rdto_resp", r, 2'b10);
    chk("rdto_data", d, 32'h0);
    chk("rdto_yumi", yumi_cnt - y0, 0);
    chk("rdto_errc", errc, err_exp);

    // Concurrent read 'hC and write 'h0, responses held four cycles
    rd_v = 4'b0010;
    rd_data[1*DW +: DW] = 32'hA5A50001;
    wrdy = '1;
    y0 = yumi_cnt; p0 = push_cnt;
    chk("cc_ready_ar", axil.arready, 1'b1);
    chk("cc_ready_aw", axil.awready, 1'b1);
    axil.araddr = 64'hC; axil.arvalid = 1'b1;
    axil.awaddr = 64'h0; axil.awvalid = 1'b1;
    axil.wdata = 32'h0BADF00D; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    tick();
    axil.arvalid = 1'b0; axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    repeat (2) tick();
    chk("cc_rvalid", axil.rvalid, 1'b1);
    chk("cc_bvalid", axil.bvalid, 1'b1);
    chk("cc_rdata", axil.rdata, 32'hA5A50001);
    chk("cc_rresp", axil.rresp, 2'b00);
    chk("cc_bresp", axil.bresp, 2'b00);
    r_d0 = axil.rdata; r_r0 = axil.rresp; b_r0 = axil.bresp;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cc_hold_rv", axil.rvalid, 1'b1);
      chk("cc_hold_rd", axil.rdata, r_d0);
      chk("cc_hold_rr", axil.rresp, r_r0);
      chk("cc_hold_bv", axil.bvalid, 1'b1);
      chk("cc_hold_br", axil.bresp, b_r0);
    end
    axil.rready = 1'b1; axil.bready = 1'b1;
    tick();
    axil.rready = 1'b0; axil.bready = 1'b0;
    wrdy = '0; rd_v = '0;
    chk("cc_rvalid_done", axil.rvalid, 1'b0);
    chk("cc_bvalid_done", axil.bvalid, 1'b0);
    chk("cc_yumi_cnt", yumi_cnt - y0, 1);
    chk("cc_yumi_vec", last_yumi, 4'b0010);
    chk("cc_push_cnt", push_cnt - p0, 1);
    chk("cc_push_v", last_push_v, 2'b01);
    chk("cc_push_d", last_push_d, 32'h0BADF00D);
    chk("cc_errc", errc, err_exp);

    // Randomized transactions against the address-arithmetic model
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 9) addr = {$urandom, $urandom} | 64'h100;
      else addr = 64'($urandom_range(0, 9) * 4 + ((sel == 8) ? 1 : 0));
      if ($urandom_range(0, 1) == 0) begin
        rd_v = 4'($urandom);
        rd_data = {$urandom, $urandom, $urandom, $urandom};
        y0 = yumi_cnt;
        if (addr >= RB && addr < RB + 4 * RD && addr % 4 == 0) begin
          ch = int'((addr - RB) / 4);
          if (rd_v[ch]) begin
            exp_r = 2'b00; exp_d = rd_data[ch*DW +: DW]; exp_lat = 2;
          end else begin
            exp_r = 2'b10; exp_d = 32'h0; exp_lat = TO + 1;
          end
        end else begin
          exp_r = 2'b11; exp_d = 32'h0; exp_lat = 1;
        end
        rd_xact(addr, $urandom_range(0, 3), d, r, lat);
        if (exp_r != 2'b00) err_exp = (err_exp >= 7) ? 7 : err_exp + 1;
        chk("rnd_rd_resp", r, exp_r);
        chk("rnd_rd_data", d, exp_d);
        chk("rnd_rd_lat", lat, exp_lat);
        chk("rnd_rd_yumi", yumi_cnt - y0, (exp_r == 2'b00) ? 1 : 0);
        rd_v = '0;
      end else begin
        wd = $urandom;
        strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        case ($urandom_range(0, 5))
          0: stall = 0; 1: stall = 1; 2: stall = 2;
          3: stall = TO - 1; 4: stall = TO; default: stall = 30;
        endcase
        push_exp = 1'b0; exp_v = '0;
        if (!(addr >= WB && addr < WB + 4 * WR && addr % 4 == 0)) begin
          exp_r = 2'b11; exp_lat = 1;
        end else if (strb != 4'hF) begin
          exp_r = 2'b10; exp_lat = 1;
        end else begin
          exp_v = 2'(1 << ((addr - WB) / 4));
          if (stall < TO) begin
            exp_r = 2'b00; exp_lat = 2 + stall; push_exp = 1'b1;
          end else begin
            exp_r = 2'b10; exp_lat = TO + 1;
          end
        end
        p0 = push_cnt;
        wr_xact(addr, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), stall, exp_v,
                $urandom_range(0, 3), r, lat);
        if (exp_r != 2'b00) err_exp = (err_exp >= 7) ? 7 : err_exp + 1;
        chk("rnd_wr_resp", r, exp_r);
        chk("rnd_wr_lat", lat, exp_lat);
        chk("rnd_wr_push", push_cnt - p0, push_exp ? 1 : 0);
        if (push_exp) begin
          chk("rnd_wr_push_v", last_push_v, exp_v);
          chk("rnd_wr_push_d", last_push_d, wd);
        end
      end
      chk("rnd_errc", errc, err_exp);
    end
    chk("onehot_fifo_side", multi_hot, 1'b0);

    // Reset asserted while a push is pending
    p0 = push_cnt;
    wrdy = '0;
    axil.awaddr = 64'h0; axil.awvalid = 1'b1;
    axil.wdata = 32'h55AA55AA; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    tick();
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    lat = 0;
    while (wv == '0 && lat < 10) begin tick(); lat++; end
    chk("rstp_wv_before", wv, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstp_wv", wv, '0);
    chk("rstp_bvalid", axil.bvalid, 1'b0);
    chk("rstp_errc", errc, '0);
    chk("rstp_awready", axil.awready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstp_arready", axil.arready, 1'b1);
    chk("rstp_awready_rel", axil.awready, 1'b1);
    chk("rstp_wready_rel", axil.wready, 1'b1);
    chk("rstp_bvalid_rel", axil.bvalid, 1'b0);
    chk("rstp_no_push", push_cnt - p0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
